// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU execute/writeback path.
// Holds the ALU opcode encoding, which the sequencer and the ALU both use, plus
// the sequencer FSM state type, instruction field positions and register-file sizes.
package cpu_pkg;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned REG_W       = 8;
    localparam int unsigned REG_AW      = 3;

    // ALU opcodes; 9..14 are illegal, 15 halts the sequencer.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_LSL = 4'd6;
    localparam logic [3:0] ALU_LSR = 4'd7;
    localparam logic [3:0] ALU_ASR = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction field positions (LSB of each field).
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned RD_LSB   = 9;
    localparam int unsigned RS1_LSB  = 6;
    localparam int unsigned IMM_BIT  = 5;
    localparam int unsigned IMM5_LSB = 0;
    localparam int unsigned RS2_LSB  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } seq_state_e;

    function automatic logic [3:0] instr_opcode(input logic [INSTR_WIDTH-1:0] ins);
        return ins[OPC_LSB +: 4];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_WIDTH-1:0] ins);
        return ins[RD_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs1(input logic [INSTR_WIDTH-1:0] ins);
        return ins[RS1_LSB +: REG_AW];
    endfunction

    function automatic logic [REG_AW-1:0] instr_rs2(input logic [INSTR_WIDTH-1:0] ins);
        return ins[RS2_LSB +: REG_AW];
    endfunction

    function automatic logic instr_is_imm(input logic [INSTR_WIDTH-1:0] ins);
        return ins[IMM_BIT];
    endfunction

    // imm5 is zero-extended, never sign-extended.
    function automatic logic [REG_W-1:0] instr_imm8(input logic [INSTR_WIDTH-1:0] ins);
        return {3'b000, ins[IMM5_LSB +: 5]};
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= ALU_ASR;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x8-bit register file for the ALU sequencer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (all registers clear to 0)
//   we, waddr, wdata    single synchronous write port
//   raddr1 / rdata1     combinational read port (rs1)
//   raddr2 / rdata2     combinational read port (rs2)
//   raddr3 / rdata3     combinational read port (debug)
// Reads return the pre-write value during a write cycle; R0 is an ordinary register.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [REG_AW-1:0] raddr1,
    output logic [REG_W-1:0]  rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [REG_W-1:0]  rdata2,
    input  logic [REG_AW-1:0] raddr3,
    output logic [REG_W-1:0]  rdata3
);

    logic [REG_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
    assign rdata3 = regs_q[raddr3];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute/writeback sequencer driving a combinational 8-bit ALU.
// Accepts one 16-bit instruction per handshake, reads operands from the internal
// register file, presents registered ALU control/operands, captures the ALU result
// and writes it back. One instruction every 4 cycles: IDLE, DECODE, EXECUTE, WRITEBACK.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid/instr_ready     instruction handshake (ready only in IDLE)
//   instr                       {opcode, rd, rs1, imm flag, imm5 | rs2}
//   ALU_control                 registered ALU opcode
//   ALU_srcdata_1/2             registered operands A = R[rs1], B = R[rs2] or imm
//   ALU_result                  combinational ALU output
//   done                        one-cycle pulse during writeback
//   illegal                     sticky flag for opcodes 9..14
//   halted                      high after HALT until reset
//   dbg_addr/dbg_data           combinational register debug read
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_WIDTH,
    parameter int unsigned NREG    = NUM_REGS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         ALU_control,
    output logic [REG_W-1:0]   ALU_srcdata_1,
    output logic [REG_W-1:0]   ALU_srcdata_2,
    input  logic [REG_W-1:0]   ALU_result,
    output logic               done,
    output logic               illegal,
    output logic               halted,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [REG_W-1:0]   dbg_data
);

    seq_state_e state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic [3:0]         alu_ctrl_q;
    logic [REG_W-1:0]   src1_q, src2_q;
    logic [REG_W-1:0]   result_q;
    logic               illegal_q;

    logic [REG_W-1:0]   rs1_data, rs2_data;
    logic               rf_we;
    logic [3:0]         opcode;

    assign opcode = instr_opcode(instr_q);

    cpu_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (instr_rd(instr_q)),
        .wdata  (result_q),
        .raddr1 (instr_rs1(instr_q)),
        .rdata1 (rs1_data),
        .raddr2 (instr_rs2(instr_q)),
        .rdata2 (rs2_data),
        .raddr3 (dbg_addr),
        .rdata3 (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_alu_op(opcode)) begin
                    state_d = StExecute;
                end else if (opcode == OP_HALT) begin
                    state_d = StHalt;
                end else begin
                    state_d = StIdle;
                end
            end
            StExecute:   state_d = StWriteback;
            StWriteback: state_d = StIdle;
            StHalt:      state_d = StHalt;
            default:     state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        halted      = 1'b0;
        rf_we       = 1'b0;
        unique case (state_q)
            StIdle:      instr_ready = 1'b1;
            StWriteback: begin
                done  = 1'b1;
                rf_we = 1'b1;
            end
            StHalt:      halted = 1'b1;
            default:     ;
        endcase
    end

    // Instruction latch, ALU operand registers, result capture and the illegal flag.
    // Operands are sampled in DECODE, so rd == rs1/rs2 always uses the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            alu_ctrl_q <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
            end
            if (state_q == StDecode) begin
                if (is_alu_op(opcode)) begin
                    alu_ctrl_q <= opcode;
                    src1_q     <= rs1_data;
                    src2_q     <= instr_is_imm(instr_q) ? instr_imm8(instr_q) : rs2_data;
                end else if (opcode != OP_HALT) begin
                    illegal_q <= 1'b1;
                end
            end
            if (state_q == StExecute) begin
                result_q <= ALU_result;
            end
        end
    end

    assign ALU_control   = alu_ctrl_q;
    assign ALU_srcdata_1 = src1_q;
    assign ALU_srcdata_2 = src2_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [3:0]  ALU_control;
    logic [7:0]  ALU_srcdata_1, ALU_srcdata_2, ALU_result;
    logic        done, illegal, halted;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] shadow [8];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .ALU_control   (ALU_control),
        .ALU_srcdata_1 (ALU_srcdata_1),
        .ALU_srcdata_2 (ALU_srcdata_2),
        .ALU_result    (ALU_result),
        .done          (done),
        .illegal       (illegal),
        .halted        (halted),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    // Ideal ALU.
    always_comb begin
        ALU_result = '0;
        case (ALU_control)
            4'd0: ALU_result = ALU_srcdata_1 + ALU_srcdata_2;
            4'd1: ALU_result = ALU_srcdata_1 - ALU_srcdata_2;
            4'd2: ALU_result = ALU_srcdata_1 & ALU_srcdata_2;
            4'd3: ALU_result = ALU_srcdata_1 | ALU_srcdata_2;
            4'd4: ALU_result = ALU_srcdata_1 ^ ALU_srcdata_2;
            4'd5: ALU_result = ~ALU_srcdata_1;
            4'd6: ALU_result = ALU_srcdata_1 << ALU_srcdata_2;
            4'd7: ALU_result = ALU_srcdata_1 >> ALU_srcdata_2;
            4'd8: ALU_result = $unsigned($signed(ALU_srcdata_1) >>> ALU_srcdata_2);
            default: ALU_result = '0;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic       imm;
        logic [4:0] bfield;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic imm,
                                        input logic [4:0] bfield);
        return {op, rd, rs1, imm, bfield};
    endfunction

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic check_all_regs(input string name);
        logic [7:0] d;
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], d);
            chk($sformatf("%s R%0d", name, r), {24'd0, d}, {24'd0, shadow[r]});
        end
    endtask

    // Present an instruction at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [15:0] ins);
        @(negedge clk);
        chk("ready before issue", {31'd0, instr_ready}, 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'hFFFF;
    endtask

    // Sample k = 1..4 negedges after acceptance: DECODE, EXECUTE, WRITEBACK, IDLE.
    task automatic run_legal(input string name, input vec_t v);
        logic [7:0] d;
        issue(enc(v.op, v.rd, v.rs1, v.imm, v.bfield));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("%s ready k=%0d", name, k), {31'd0, instr_ready}, 32'd0);
            end
            if (k == 2) begin
                chk({name, " ctrl"}, {28'd0, ALU_control}, {28'd0, v.op});
                chk({name, " src1"}, {24'd0, ALU_srcdata_1}, {24'd0, v.exp_a});
                chk({name, " src2"}, {24'd0, ALU_srcdata_2}, {24'd0, v.exp_b});
            end
            if (k == 3) begin
                chk({name, " done"}, {31'd0, done}, 32'd1);
                read_reg(v.rd, d);
                chk({name, " dbg pre-write"}, {24'd0, d}, {24'd0, shadow[v.rd]});
            end else begin
                chk($sformatf("%s no done k=%0d", name, k), {31'd0, done}, 32'd0);
            end
            if (k == 4) begin
                chk({name, " ready again"}, {31'd0, instr_ready}, 32'd1);
                shadow[v.rd] = v.exp_res;
                read_reg(v.rd, d);
                chk({name, " result"}, {24'd0, d}, {24'd0, v.exp_res});
            end
        end
    endtask

    initial begin
        vec_t v;
        for (int r = 0; r < 8; r++) shadow[r] = '0;

        //           op    rd    rs1   imm   bfield  a      b      res
        vecs[0]  = '{4'd0, 3'd1, 3'd0, 1'b1, 5'd5,  8'h00, 8'h05, 8'h05};
        vecs[1]  = '{4'd0, 3'd2, 3'd0, 1'b1, 5'd3,  8'h00, 8'h03, 8'h03};
        vecs[2]  = '{4'd1, 3'd3, 3'd1, 1'b0, 5'd2,  8'h05, 8'h03, 8'h02};
        vecs[3]  = '{4'd0, 3'd4, 3'd0, 1'b1, 5'h1F, 8'h00, 8'h1F, 8'h1F};
        vecs[4]  = '{4'd6, 3'd4, 3'd4, 1'b1, 5'd3,  8'h1F, 8'h03, 8'hF8};
        vecs[5]  = '{4'd8, 3'd5, 3'd4, 1'b1, 5'd2,  8'hF8, 8'h02, 8'hFE};
        vecs[6]  = '{4'd1, 3'd6, 3'd0, 1'b0, 5'd4,  8'h00, 8'hF8, 8'h08};
        vecs[7]  = '{4'd4, 3'd7, 3'd4, 1'b0, 5'd5,  8'hF8, 8'hFE, 8'h06};
        vecs[8]  = '{4'd2, 3'd1, 3'd4, 1'b0, 5'd5,  8'hF8, 8'hFE, 8'hF8};
        vecs[9]  = '{4'd3, 3'd2, 3'd1, 1'b0, 5'd3,  8'hF8, 8'h02, 8'hFA};
        vecs[10] = '{4'd5, 3'd3, 3'd6, 1'b0, 5'd0,  8'h08, 8'h00, 8'hF7};
        vecs[11] = '{4'd7, 3'd0, 3'd4, 1'b1, 5'd4,  8'hF8, 8'h04, 8'h0F};
        vecs[12] = '{4'd0, 3'd0, 3'd0, 1'b0, 5'd0,  8'h0F, 8'h0F, 8'h1E};

        // Reset state.
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", {31'd0, instr_ready}, 32'd1);
        chk("reset ctrl", {28'd0, ALU_control}, 32'd0);
        chk("reset src1", {24'd0, ALU_srcdata_1}, 32'd0);
        chk("reset src2", {24'd0, ALU_srcdata_2}, 32'd0);
        chk("reset flags", {29'd0, done, illegal, halted}, 32'd0);
        check_all_regs("reset");

        // Directed program.
        for (int i = 0; i < 13; i++) begin
            run_legal($sformatf("vec%0d", i), vecs[i]);
        end
        check_all_regs("after program");

        // Illegal opcode: back to IDLE two cycles after acceptance, nothing written.
        issue(enc(4'b1010, 3'd1, 3'd2, 1'b1, 5'd7));
        @(negedge clk);
        chk("illegal k1 ready", {31'd0, instr_ready}, 32'd0);
        chk("illegal k1 done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("illegal k2 ready", {31'd0, instr_ready}, 32'd1);
        chk("illegal flag", {31'd0, illegal}, 32'd1);
        chk("illegal k2 done", {31'd0, done}, 32'd0);
        chk("illegal ctrl kept", {28'd0, ALU_control}, 32'd0);
        chk("illegal src1 kept", {24'd0, ALU_srcdata_1}, 32'h0F);
        chk("illegal src2 kept", {24'd0, ALU_srcdata_2}, 32'h0F);
        @(negedge clk);
        chk("illegal k3 done", {31'd0, done}, 32'd0);
        check_all_regs("after illegal");

        v = '{4'd0, 3'd5, 3'd0, 1'b1, 5'd1, 8'h1E, 8'h01, 8'h1F};
        run_legal("post-illegal", v);
        chk("illegal sticky", {31'd0, illegal}, 32'd1);

        // HALT holds off new instructions until reset.
        issue(16'hF000);
        instr_valid = 1'b1;
        instr = enc(4'd0, 3'd1, 3'd0, 1'b1, 5'd9);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("halt c%0d halted", c), {31'd0, halted}, 32'd1);
            chk($sformatf("halt c%0d ready", c), {31'd0, instr_ready}, 32'd0);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt reset ready", {31'd0, instr_ready}, 32'd1);
        chk("halt reset flags", {29'd0, done, illegal, halted}, 32'd0);
        for (int r = 0; r < 8; r++) shadow[r] = '0;
        check_all_regs("halt reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during EXECUTE aborts the writeback.
        issue(enc(4'd0, 3'd7, 3'd0, 1'b1, 5'd9));
        @(negedge clk);
        @(negedge clk);
        chk("abort exec src2", {24'd0, ALU_srcdata_2}, 32'd9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort src2 async", {24'd0, ALU_srcdata_2}, 32'd0);
        chk("abort ctrl async", {28'd0, ALU_control}, 32'd0);
        chk("abort src1 async", {24'd0, ALU_srcdata_1}, 32'd0);
        chk("abort ready async", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort no done c%0d", c), {31'd0, done}, 32'd0);
        end
        check_all_regs("after abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer driving the 8-bit ALU from the controller side. It accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8x8-bit register file, and presents `ALU_control`, `ALU_srcdata_1` and `ALU_srcdata_2` as registered outputs. It captures `ALU_result` and writes it back to the destination register. It sits between instruction fetch and the combinational ALU, and is the execute/writeback control of the CPU.

## Interface
- `INSTR_W`, 16: instruction width; fixed format below, not meant to be changed.
- `NREG`, 8: register count; 3-bit register addresses.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  instruction available.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `instr`  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5] imm flag, [4:0] imm5 (imm flag=1) or [2:0] rs2 (imm flag=0).
- `ALU_control`  out  4  registered ALU opcode.
- `ALU_srcdata_1`  out  8  registered operand A = R[rs1].
- `ALU_srcdata_2`  out  8  registered operand B = R[rs2], or {3'b000, imm5}.
- `ALU_result`  in  8  combinational ALU output.
- `done`  out  1  one-cycle pulse on register writeback.
- `illegal`  out  1  sticky flag; set on an opcode in 9..14.
- `halted`  out  1  high after HALT (opcode 15) until reset.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  8  combinational R[dbg_addr].

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LSL, 7 LSR, 8 ASR. Codes 9–14 are illegal. 15 is HALT.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE: `instr_ready`=1. When `instr_valid`&&`instr_ready`, latch `instr` and go to DECODE.
  - DECODE:
    - Opcode 0–8: register `ALU_control`, `ALU_srcdata_1` and `ALU_srcdata_2`, then go to EXECUTE.
    - Opcode 9–14: set `illegal`, leave ALU outputs unchanged, return to IDLE. No writeback, no `done`.
    - Opcode 15: go to HALT.
  - EXECUTE: capture `ALU_result` into an internal result register, then go to WRITEBACK.
  - WRITEBACK: write R[rd] ← result at the clock edge ending this state. `done`=1 during this state. Next state is IDLE.
  - HALT: `halted`=1 and `instr_ready`=0. The FSM stays here until `rst_n` is low.
- Immediate: imm5 is zero-extended to 8 bits; there is no sign extension.
- Register 0 is an ordinary register and is not hardwired to zero.
- For NOT, operand B is still formed and driven but is ignored by the ALU.
- Shift amounts use the full 8-bit operand B.
- All arithmetic is modulo 2^8. There is no carry or overflow output.
- `dbg_data` shows the value before a same-cycle write. The new value is visible the cycle after WRITEBACK.

## Timing
- Reset values (async, immediate on `rst_n` low):
  - FSM state = IDLE, so `instr_ready`=1.
  - `ALU_control`=4'b0000, `ALU_srcdata_1`=0, `ALU_srcdata_2`=0.
  - `done`=0, `illegal`=0, `halted`=0.
  - All registers R0–R7 = 0.
- Legal ALU instruction accepted at edge T:
  - DECODE in cycle T+1; ALU outputs are valid from edge T+2.
  - EXECUTE in cycle T+2, with result capture at edge T+3.
  - WRITEBACK in cycle T+3, with `done`=1 and the register write at edge T+4.
  - `instr_ready` is high again in cycle T+4.
- Throughput: one instruction per 4 cycles.
- Illegal opcode: `instr_ready` returns high in cycle T+2, and `illegal` is visible from T+2.
- `instr_valid` may drop or change while `instr_ready`=0; it is ignored.
- Reset asserted mid-instruction aborts immediately. There is no writeback and no `done`.
- When rd equals rs1 or rs2, the operands are read in DECODE, before the write, so the old values are used.

## Structure
- Package `cpu_pkg` holds:
  - ALU opcode localparams ADD..ASR and OP_HALT.
  - The FSM state enum.
  - Instruction field bit positions.
  - The register-count and width constants.
- The ALU opcode localparams are shared with the ALU so both sides use one definition.
- Sub-module `cpu_regfile`: 8x8 bits, async reset, 1 synchronous write port, 3 combinational read ports (rs1, rs2, dbg).
- The sequencer FSM and the output registers live in `alu_sequencer`.

## Test plan
- Reset, then `dbg_addr`=0..7 → every `dbg_data`=0, `instr_ready`=1, `ALU_control`=0.
- Immediate load: ADD R1=R0+imm 5, then ADD R2=R0+imm 3, then SUB R3=R1−R2 → R3=8'h02. Each instruction gives `done` exactly 3 cycles after acceptance and `instr_ready` 4 cycles after.
- Shift and wrap:
  - Load R4=0x1F via imm, then LSL R4=R4<<imm 3 → R4=0xF8.
  - ASR R5=R4>>>imm 2 → R5=0xFE.
  - SUB R6=R0−R4 with R0=0 → 0x08.
  - With an ideal ALU model in the bench.
- Illegal opcode 4'b1010 → `illegal`=1 sticky, no `done`, registers unchanged, `instr_ready` high 2 cycles after acceptance. The next legal instruction executes normally.
- HALT accepted → `halted`=1 and `instr_ready`=0 for 20 cycles despite `instr_valid`=1. Then `rst_n` pulse → IDLE with all flags cleared.
- Reset during EXECUTE of ADD R7=R0+imm 9 → R7 stays 0, no `done`, ALU outputs return to 0 asynchronously.
